coarse_fifo_symbol_reader: RTL

Read-side controller for the receiver's coarse-sync sample FIFO. It waits until a full OFDM symbol (cyclic prefix + body) is buffered, then drains it. It discards the CP samples and streams the N_FFT body samples to the FFT front end over a valid/ready interface, with back-pressure and a last-sample marker. It is the consumer matching the FIFO's writer, and sits between the coarse FIFO and the FFT input stage.

---
 rtl/coarse_fifo_symbol_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/coarse_fifo_symbol_reader.sv
// Drains one OFDM symbol from the coarse-sync FIFO: drops the CP, streams N_FFT body samples.
// Latency: FIFO read to m_valid is 2 cycles; reads start the cycle after the start condition.
// Backpressure: m_ready stalls via a 2-entry output buffer; reads are credit-gated so it never overflows.
module coarse_fifo_symbol_reader #(
  parameter int DATA_W  = 16,
  parameter int CP_LEN  = 16,
  parameter int N_FFT   = 64,
  parameter int SYM_LEN = CP_LEN + N_FFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [8:0]        fifo_count,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_r_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              sym_done,
  output logic [7:0]        sym_cnt,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(SYM_LEN);
  localparam logic [IDX_W-1:0] CP_LAST  = IDX_W'(CP_LEN - 1);
  localparam logic [IDX_W-1:0] CP_END   = IDX_W'(CP_LEN);
  localparam logic [IDX_W-1:0] SYM_LAST = IDX_W'(SYM_LEN - 1);

  typedef enum logic [1:0] {S_WAIT, S_DROP_CP, S_PASS, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rd_idx;     // reads issued within the current symbol
  logic [IDX_W-1:0]  rx_idx;     // samples returned within the current symbol
  logic              inflight;   // a read was issued last cycle, data returns now
  logic [1:0]        occ;
  logic [DATA_W-1:0] dat0, dat1;
  logic              last0, last1;
  logic              pop, push, push_last;
  logic [2:0]        credit_sum;

  assign pop        = m_valid && m_ready;
  assign push       = inflight && (rx_idx >= CP_END);
  assign push_last  = (rx_idx == SYM_LAST);
  // Occupancy the buffer would reach if everything already committed lands.
  assign credit_sum = 3'(occ) - 3'(pop) + 3'(inflight);

  assign m_data   = dat0;
  assign m_valid  = (occ != 2'd0);
  assign m_last   = m_valid && last0;
  assign busy     = (state != S_WAIT);
  assign sym_done = (state == S_DRAIN) && pop && m_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // Next-state and read-strobe decode.
  always_comb begin
    state_nxt = state;
    fifo_r_en = 1'b0;
    case (state)
      S_WAIT: begin
        if (en && (fifo_count >= 9'(SYM_LEN))) state_nxt = S_DROP_CP;
      end
      S_DROP_CP: begin
        fifo_r_en = !fifo_empty;
        if (fifo_r_en && (rd_idx == CP_LAST)) state_nxt = S_PASS;
      end
      S_PASS: begin
        fifo_r_en = !fifo_empty && (credit_sum < 3'd2);
        if (fifo_r_en && (rd_idx == SYM_LAST)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (sym_done) state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Read and return indices; the return index decides drop vs. forward and tags the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx   <= '0;
      rx_idx   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      if (fifo_r_en) rd_idx <= (rd_idx == SYM_LAST) ? '0 : rd_idx + 1'b1;
      if (inflight)  rx_idx <= (rx_idx == SYM_LAST) ? '0 : rx_idx + 1'b1;
    end
  end

  // Two-entry output buffer; entry 0 is the head presented downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      dat0  <= '0;
      dat1  <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            dat0  <= fifo_dout;
            last0 <= push_last;
          end else begin
            dat1  <= fifo_dout;
            last1 <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          dat0  <= dat1;
          last0 <= last1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            dat0  <= fifo_dout;
            last0 <= push_last;
          end else begin
            dat0  <= dat1;
            last0 <= last1;
            dat1  <= fifo_dout;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Completed-symbol counter and sticky read-return error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= 8'd0;
      err     <= 1'b0;
    end else begin
      if (sym_done) sym_cnt <= sym_cnt + 8'd1;
      if (inflight && !fifo_r_valid) err <= 1'b1;
    end
  end

endmodule
